// File: rtl/bpu_pkg.sv
// Shared types for the branch resolve unit: prediction entry, FSM state and
// the mispredict rule used when a resolved branch is compared to its prediction.
package bpu_pkg;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } pred_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  // A not-taken branch never redirects, so its target is irrelevant.
  function automatic logic entry_mismatch(input pred_entry_t e,
                                          input logic [31:0] pc,
                                          input logic [31:0] target,
                                          input logic        taken);
    return (e.pc != pc) || (e.taken != taken) || (taken && (e.target != target));
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bundle of the branch resolve unit; the unit uses the
// slave modport, the pipeline (or a bench) drives through master.
interface branch_resolve_unit_if;
  logic        PushValid;
  logic [31:0] PushPC;
  logic [31:0] PushPredTarget;
  logic        PushPredTaken;
  logic        ResolveValid;
  logic [31:0] ResolvePC;
  logic [31:0] ResolveTarget;
  logic        ResolveTaken;
  logic        Full;
  logic        UpdateEnable;
  logic        BranchTaken;
  logic [31:0] PCUpdate;
  logic [31:0] PCBranch;
  logic        Mispredict;
  logic [31:0] RedirectPC;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  modport master (
    output PushValid, PushPC, PushPredTarget, PushPredTaken,
    output ResolveValid, ResolvePC, ResolveTarget, ResolveTaken,
    input  Full, UpdateEnable, BranchTaken, PCUpdate, PCBranch,
    input  Mispredict, RedirectPC, BranchCount, MispredictCount
  );

  modport slave (
    input  PushValid, PushPC, PushPredTarget, PushPredTaken,
    input  ResolveValid, ResolvePC, ResolveTarget, ResolveTaken,
    output Full, UpdateEnable, BranchTaken, PCUpdate, PCBranch,
    output Mispredict, RedirectPC, BranchCount, MispredictCount
  );
endinterface

// File: rtl/pred_fifo.sv
// In-order queue of outstanding branch predictions. Head is visible
// combinationally so the resolve compare happens in the same cycle.
module pred_fifo
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  pred_entry_t wdata_i,
  output logic        full_o,
  output logic        empty_o,
  output pred_entry_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;
  pred_entry_t      mem_q [DEPTH];

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the write lands in, so push into a full queue is legal then.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && !flush_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches execute-stage branch outcomes against queued fetch predictions,
// drives BTB updates, flush/redirect pulses and performance counters.
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RC_W-1:0] REC_LAST = RC_W'(RECOVER_CYCLES - 1);

  bru_state_e  state_q, state_d;
  logic [RC_W-1:0] rec_cnt_q, rec_cnt_d;
  logic        run;

  logic        fifo_full, fifo_empty;
  pred_entry_t head, cmp_entry, push_entry;
  logic        resolve_acc, mispredict_det, pop, push;
  logic [31:0] redirect_d;

  logic        update_en_q, taken_q, mispredict_q;
  logic [31:0] pc_update_q, pc_branch_q, redirect_q;
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (mispredict_det),
    .wdata_i (push_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      RUN: begin
        if (mispredict_det) begin
          state_d   = RECOVER;
          rec_cnt_d = '0;
        end
      end
      RECOVER: begin
        if (rec_cnt_q == REC_LAST) begin
          state_d   = RUN;
          rec_cnt_d = '0;
        end else begin
          rec_cnt_d = rec_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    run = (state_q == RUN);
  end

  // An empty queue means fetch predicted fall-through for this branch.
  always_comb begin
    cmp_entry = head;
    if (fifo_empty) begin
      cmp_entry.pc     = bus.ResolvePC;
      cmp_entry.target = '0;
      cmp_entry.taken  = 1'b0;
    end
    push_entry.pc     = bus.PushPC;
    push_entry.target = bus.PushPredTarget;
    push_entry.taken  = bus.PushPredTaken;
    resolve_acc    = run && bus.ResolveValid;
    mispredict_det = resolve_acc &&
                     entry_mismatch(cmp_entry, bus.ResolvePC, bus.ResolveTarget, bus.ResolveTaken);
    pop            = resolve_acc && !fifo_empty;
    push           = run && bus.PushValid && (!fifo_full || pop) && !mispredict_det;
    redirect_d     = bus.ResolveTaken ? bus.ResolveTarget : (bus.ResolvePC + PC_INC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      update_en_q      <= 1'b0;
      taken_q          <= 1'b0;
      pc_update_q      <= '0;
      pc_branch_q      <= '0;
      mispredict_q     <= 1'b0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      update_en_q  <= resolve_acc;
      mispredict_q <= mispredict_det;
      if (resolve_acc) begin
        taken_q      <= bus.ResolveTaken;
        pc_update_q  <= bus.ResolvePC;
        pc_branch_q  <= bus.ResolveTarget;
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispredict_det) begin
        redirect_q       <= redirect_d;
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign bus.Full            = fifo_full;
  assign bus.UpdateEnable    = update_en_q;
  assign bus.BranchTaken     = taken_q;
  assign bus.PCUpdate        = pc_update_q;
  assign bus.PCBranch        = pc_branch_q;
  assign bus.Mispredict      = mispredict_q;
  assign bus.RedirectPC      = redirect_q;
  assign bus.BranchCount     = branch_cnt_q;
  assign bus.MispredictCount = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, a reset-with-full-queue
// sequence, then randomized traffic against a queue-based reference model.
module tb_branch_resolve_unit;
  import bpu_pkg::*;

  localparam int DEPTH          = 4;
  localparam int RECOVER_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_unit_if bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic rst; logic pv; logic [31:0] ppc; logic [31:0] ptgt; logic ptk;
    logic rv; logic [31:0] rpc; logic [31:0] rtgt; logic rtk;
  } stim_t;

  typedef struct {
    logic full; logic upd; logic btk; logic [31:0] pcupd; logic [31:0] pcbr;
    logic mis; logic [31:0] redir; logic [31:0] bcnt; logic [31:0] mcnt;
  } outs_t;

  typedef struct { stim_t s; outs_t e; } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of outstanding predictions plus a suppression countdown.
  pred_entry_t mq[$];
  int          m_rec;
  outs_t       m;

  function automatic stim_t st(input logic rst, input logic pv, input logic [31:0] ppc,
                               input logic [31:0] ptgt, input logic ptk, input logic rv,
                               input logic [31:0] rpc, input logic [31:0] rtgt, input logic rtk);
    stim_t s;
    s.rst = rst; s.pv = pv; s.ppc = ppc; s.ptgt = ptgt; s.ptk = ptk;
    s.rv = rv; s.rpc = rpc; s.rtgt = rtgt; s.rtk = rtk;
    return s;
  endfunction

  function automatic outs_t ex(input logic full, input logic upd, input logic btk,
                               input logic [31:0] pcupd, input logic [31:0] pcbr, input logic mis,
                               input logic [31:0] redir, input logic [31:0] bcnt, input logic [31:0] mcnt);
    outs_t o;
    o.full = full; o.upd = upd; o.btk = btk; o.pcupd = pcupd; o.pcbr = pcbr;
    o.mis = mis; o.redir = redir; o.bcnt = bcnt; o.mcnt = mcnt;
    return o;
  endfunction

  task automatic model_step(input stim_t s);
    pred_entry_t h;
    pred_entry_t e;
    logic        bad;
    logic        popped;
    int          n_before;
    if (s.rst) begin
      mq.delete();
      m_rec = 0;
      m = ex(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      return;
    end
    m.upd = 1'b0;
    m.mis = 1'b0;
    if (m_rec > 0) begin
      m_rec--;
    end else begin
      n_before = mq.size();
      bad = 1'b0;
      popped = 1'b0;
      if (s.rv) begin
        if (n_before > 0) begin
          h = mq.pop_front();
          popped = 1'b1;
        end else begin
          h.pc = s.rpc; h.target = 32'h0; h.taken = 1'b0;
        end
        bad = (h.pc != s.rpc) || (h.taken != s.rtk) || (s.rtk && (h.target != s.rtgt));
        m.upd = 1'b1; m.btk = s.rtk; m.pcupd = s.rpc; m.pcbr = s.rtgt;
        m.bcnt = m.bcnt + 32'd1;
      end
      if (bad) begin
        mq.delete();
        m_rec = RECOVER_CYCLES;
        m.mis = 1'b1;
        m.mcnt = m.mcnt + 32'd1;
        m.redir = s.rtk ? s.rtgt : (s.rpc + 32'd4);
      end else if (s.pv && ((n_before < DEPTH) || popped)) begin
        e.pc = s.ppc; e.target = s.ptgt; e.taken = s.ptk;
        mq.push_back(e);
      end
    end
    m.full = (mq.size() == DEPTH);
  endtask

  task automatic apply(input stim_t s);
    reset              = s.rst;
    bus.PushValid      = s.pv;
    bus.PushPC         = s.ppc;
    bus.PushPredTarget = s.ptgt;
    bus.PushPredTaken  = s.ptk;
    bus.ResolveValid   = s.rv;
    bus.ResolvePC      = s.rpc;
    bus.ResolveTarget  = s.rtgt;
    bus.ResolveTaken   = s.rtk;
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%0h required 0x%0h", tag, nm, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input outs_t e);
    chk(tag, "Full",            32'(bus.Full),         32'(e.full));
    chk(tag, "UpdateEnable",    32'(bus.UpdateEnable), 32'(e.upd));
    chk(tag, "BranchTaken",     32'(bus.BranchTaken),  32'(e.btk));
    chk(tag, "PCUpdate",        bus.PCUpdate,          e.pcupd);
    chk(tag, "PCBranch",        bus.PCBranch,          e.pcbr);
    chk(tag, "Mispredict",      32'(bus.Mispredict),   32'(e.mis));
    chk(tag, "RedirectPC",      bus.RedirectPC,        e.redir);
    chk(tag, "BranchCount",     bus.BranchCount,       e.bcnt);
    chk(tag, "MispredictCount", bus.MispredictCount,   e.mcnt);
  endtask

  task automatic show(input string tag, input stim_t s);
    $display("%s rst=%b push=%b pc=%h resolve=%b rpc=%h tk=%b -> upd=%b mis=%b redir=%h full=%b bc=%0d mc=%0d",
             tag, s.rst, s.pv, s.ppc, s.rv, s.rpc, s.rtk, bus.UpdateEnable, bus.Mispredict,
             bus.RedirectPC, bus.Full, bus.BranchCount, bus.MispredictCount);
  endtask

  vec_t  tbl[$];
  stim_t s;
  stim_t idle;

  initial begin
    idle = st(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    // reset, then correct taken resolve
    tbl.push_back('{st(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0)});
    tbl.push_back('{st(1'b0, 1'b1, 'h100, 'h200, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h100, 'h200, 1'b1), ex(1'b0, 1'b1, 1'b1, 'h100, 'h200, 1'b0, 0, 1, 0)});
    // direction mispredict, recovery window ignores traffic, queue left empty
    tbl.push_back('{st(1'b0, 1'b1, 'h100, 'h200, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b1, 'h100, 'h200, 1'b0, 0, 1, 0)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h100, 'h200, 1'b0), ex(1'b0, 1'b1, 1'b0, 'h100, 'h200, 1'b1, 'h104, 2, 1)});
    tbl.push_back('{st(1'b0, 1'b1, 'h500, 'h600, 1'b1, 1'b1, 'h500, 'h600, 1'b1), ex(1'b0, 1'b0, 1'b0, 'h100, 'h200, 1'b0, 'h104, 2, 1)});
    tbl.push_back('{st(1'b0, 1'b1, 'h500, 'h600, 1'b1, 1'b1, 'h500, 'h600, 1'b1), ex(1'b0, 1'b0, 1'b0, 'h100, 'h200, 1'b0, 'h104, 2, 1)});
    tbl.push_back('{idle, ex(1'b0, 1'b0, 1'b0, 'h100, 'h200, 1'b0, 'h104, 2, 1)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h700, 'h800, 1'b0), ex(1'b0, 1'b1, 1'b0, 'h700, 'h800, 1'b0, 'h104, 3, 1)});
    // fill, overflow drop, push+pop while full
    tbl.push_back('{st(1'b0, 1'b1, 'h1000, 'h2000, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b0, 'h700, 'h800, 1'b0, 'h104, 3, 1)});
    tbl.push_back('{st(1'b0, 1'b1, 'h1010, 'h2010, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b0, 'h700, 'h800, 1'b0, 'h104, 3, 1)});
    tbl.push_back('{st(1'b0, 1'b1, 'h1020, 'h2020, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b0, 'h700, 'h800, 1'b0, 'h104, 3, 1)});
    tbl.push_back('{st(1'b0, 1'b1, 'h1030, 'h2030, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b1, 1'b0, 1'b0, 'h700, 'h800, 1'b0, 'h104, 3, 1)});
    tbl.push_back('{st(1'b0, 1'b1, 'h1040, 'h2040, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b1, 1'b0, 1'b0, 'h700, 'h800, 1'b0, 'h104, 3, 1)});
    tbl.push_back('{st(1'b0, 1'b1, 'h1050, 'h2050, 1'b0, 1'b1, 'h1000, 'h2000, 1'b1), ex(1'b1, 1'b1, 1'b1, 'h1000, 'h2000, 1'b0, 'h104, 4, 1)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h1010, 'h2010, 1'b1), ex(1'b0, 1'b1, 1'b1, 'h1010, 'h2010, 1'b0, 'h104, 5, 1)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h1020, 'h2020, 1'b1), ex(1'b0, 1'b1, 1'b1, 'h1020, 'h2020, 1'b0, 'h104, 6, 1)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h1030, 'h2030, 1'b1), ex(1'b0, 1'b1, 1'b1, 'h1030, 'h2030, 1'b0, 'h104, 7, 1)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h1050, 'h1054, 1'b0), ex(1'b0, 1'b1, 1'b0, 'h1050, 'h1054, 1'b0, 'h104, 8, 1)});
    // taken resolve against empty queue, two ignored cycles, third accepted
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h300, 'h400, 1'b1), ex(1'b0, 1'b1, 1'b1, 'h300, 'h400, 1'b1, 'h400, 9, 2)});
    tbl.push_back('{st(1'b0, 1'b1, 'h900, 'hA00, 1'b1, 1'b1, 'h900, 'hA00, 1'b1), ex(1'b0, 1'b0, 1'b1, 'h300, 'h400, 1'b0, 'h400, 9, 2)});
    tbl.push_back('{st(1'b0, 1'b1, 'h900, 'hA00, 1'b1, 1'b1, 'h900, 'hA00, 1'b1), ex(1'b0, 1'b0, 1'b1, 'h300, 'h400, 1'b0, 'h400, 9, 2)});
    tbl.push_back('{st(1'b0, 1'b1, 'hB00, 'hC00, 1'b1, 1'b1, 'h900, 'h904, 1'b0), ex(1'b0, 1'b1, 1'b0, 'h900, 'h904, 1'b0, 'h400, 10, 2)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'hB00, 'hC00, 1'b1), ex(1'b0, 1'b1, 1'b1, 'hB00, 'hC00, 1'b0, 'h400, 11, 2)});
    // three queued, target mispredict, reset during recovery
    tbl.push_back('{st(1'b0, 1'b1, 'hD00, 'hE00, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b1, 'hB00, 'hC00, 1'b0, 'h400, 11, 2)});
    tbl.push_back('{st(1'b0, 1'b1, 'hD10, 'hE10, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b1, 'hB00, 'hC00, 1'b0, 'h400, 11, 2)});
    tbl.push_back('{st(1'b0, 1'b1, 'hD20, 'hE20, 1'b1, 1'b0, 0, 0, 1'b0), ex(1'b0, 1'b0, 1'b1, 'hB00, 'hC00, 1'b0, 'h400, 11, 2)});
    tbl.push_back('{st(1'b0, 1'b1, 'hD30, 'hE30, 1'b1, 1'b1, 'hD00, 'hE04, 1'b1), ex(1'b0, 1'b1, 1'b1, 'hD00, 'hE04, 1'b1, 'hE04, 12, 3)});
    tbl.push_back('{st(1'b1, 1'b1, 'hF00, 'hF04, 1'b1, 1'b1, 'hF00, 'hF04, 1'b1), ex(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0)});
    tbl.push_back('{st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h1200, 'h1300, 1'b0), ex(1'b0, 1'b1, 1'b0, 'h1200, 'h1300, 1'b0, 0, 1, 0)});

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].s);
      show($sformatf("vec%0d", i), tbl[i].s);
      chk_all($sformatf("vec%0d", i), tbl[i].e);
    end

    // Reset with a full queue must leave it empty: a taken resolve then mispredicts.
    for (int k = 0; k < DEPTH; k++) begin
      s = st(1'b0, 1'b1, 32'h2000 + 32'(k * 16), 32'h3000 + 32'(k * 16), 1'b1, 1'b0, 0, 0, 1'b0);
      apply(s);
      show($sformatf("seq_fill%0d", k), s);
    end
    chk("seq_fill", "Full", 32'(bus.Full), 32'd1);
    s = st(1'b1, 1'b1, 'h2040, 'h3040, 1'b1, 1'b1, 'h2000, 'h3000, 1'b1);
    apply(s);
    show("seq_reset", s);
    chk("seq_reset", "Full", 32'(bus.Full), 32'd0);
    chk("seq_reset", "BranchCount", bus.BranchCount, 32'd0);
    chk("seq_reset", "UpdateEnable", 32'(bus.UpdateEnable), 32'd0);
    s = st(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 'h2000, 'h3000, 1'b1);
    apply(s);
    show("seq_after", s);
    chk("seq_after", "Mispredict", 32'(bus.Mispredict), 32'd1);
    chk("seq_after", "RedirectPC", bus.RedirectPC, 32'h3000);
    chk("seq_after", "MispredictCount", bus.MispredictCount, 32'd1);
    chk("seq_after", "BranchCount", bus.BranchCount, 32'd1);

    apply(st(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0));
    for (int c = 0; c < 1500; c++) begin
      int unsigned thr;
      thr = ((c % 400) < 200) ? 3 : 7;
      s.rst  = ($urandom_range(0, 199) == 0);
      s.pv   = 1'($urandom_range(0, 1));
      s.ppc  = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
      s.ptgt = 32'h8000 + 32'($urandom_range(0, 15)) * 32'd4;
      s.ptk  = 1'($urandom_range(0, 1));
      s.rv   = ($urandom_range(0, 9) < thr);
      if ((mq.size() > 0) && ($urandom_range(0, 3) != 0)) begin
        s.rpc  = mq[0].pc;
        s.rtgt = mq[0].target;
        s.rtk  = mq[0].taken;
        case ($urandom_range(0, 7))
          0: s.rtk  = ~s.rtk;
          1: s.rtgt = s.rtgt ^ 32'h4;
          default: ;
        endcase
      end else begin
        s.rpc  = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
        s.rtgt = 32'h8000 + 32'($urandom_range(0, 15)) * 32'd4;
        s.rtk  = 1'($urandom_range(0, 1));
      end
      apply(s);
      show($sformatf("rnd%0d", c), s);
      chk_all($sformatf("rnd%0d", c), m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
